// File: rtl/aes_output_buffer.sv
// AES output buffer: captures a 128-bit result block on done_i and serialises it
// onto a 32-bit valid/ready bus, pulsing done_o after the final word is taken.
module aes_output_buffer #(
    parameter bit LSW_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done_i,
    input  logic [127:0] text_i,
    input  logic         rd_i,
    output logic [31:0]  text_out,
    output logic         valid_o,
    output logic         last_o,
    output logic         done_o,
    output logic         busy_o,
    output logic         overrun_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state;
    state_t       state_n;
    logic [1:0]   cnt;
    logic [1:0]   cnt_n;
    logic [127:0] data;
    logic [127:0] data_n;
    logic         overrun_n;
    logic         done_n;
    logic         xfer;
    logic         final_xfer;

    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
        logic [1:0] w;
        w = LSW_FIRST ? idx : (2'd3 - idx);
        case (w)
            2'd0:    return blk[31:0];
            2'd1:    return blk[63:32];
            2'd2:    return blk[95:64];
            default: return blk[127:96];
        endcase
    endfunction

    // valid_o mirrors state==SEND, so a beat is simply SEND with rd_i high
    assign xfer       = (state == SEND) && rd_i;
    assign final_xfer = xfer && (cnt == 2'd3);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        data_n    = data;
        overrun_n = overrun_o;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (done_i) begin
                    data_n  = text_i;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (final_xfer) begin
                    done_n = 1'b1;
                    cnt_n  = '0;
                    if (done_i) begin
                        data_n = text_i;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cnt_n = cnt + 2'd1;
                    end
                    if (done_i) begin
                        overrun_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they align with state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            data      <= '0;
            text_out  <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            data      <= data_n;
            text_out  <= word_sel(data_n, cnt_n);
            valid_o   <= (state_n == SEND);
            busy_o    <= (state_n == SEND);
            last_o    <= (state_n == SEND) && (cnt_n == 2'd3);
            done_o    <= done_n;
            overrun_o <= overrun_n;
        end
    end

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed bench for aes_output_buffer; runs both word orders side by side.
module tb_aes_output_buffer;

    localparam logic [127:0] T1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] T2 = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;

    logic         clk;
    logic         rst;
    logic         done_i;
    logic [127:0] text_i;
    logic         rd_i;

    logic [31:0] text1, text0;
    logic        valid1, valid0, last1, last0, done1, done0;
    logic        busy1, busy0, ovr1, ovr0;

    int total;
    int bad;
    int ndone;
    int ndone0;
    int nxfer;
    int snap_d;
    int snap_x;

    aes_output_buffer #(.LSW_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i), .rd_i(rd_i),
        .text_out(text1), .valid_o(valid1), .last_o(last1), .done_o(done1),
        .busy_o(busy1), .overrun_o(ovr1)
    );

    aes_output_buffer #(.LSW_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i), .rd_i(rd_i),
        .text_out(text0), .valid_o(valid0), .last_o(last0), .done_o(done0),
        .busy_o(busy0), .overrun_o(ovr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ndone  = 0;
        ndone0 = 0;
        nxfer  = 0;
    end

    always @(negedge clk) begin
        if (done1) ndone++;
        if (done0) ndone0++;
        if (valid1 && rd_i) nxfer++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        done_i = 1'b0;
        text_i = '0;
        rd_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_text1", text1, 32'h0);
        chk("rst_text0", text0, 32'h0);
        chk("rst_last", last1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_ovr", ovr1, 1'b0);
        rst = 1'b1;
        tick();

        // continuous rd_i
        snap_d = ndone; snap_x = nxfer;
        rd_i = 1'b1; done_i = 1'b1; text_i = T1;
        tick();
        done_i = 1'b0; text_i = '0;
        chk("t1_valid", valid1, 1'b1);
        chk("t1_busy", busy1, 1'b1);
        chk("t1_w0", text1, 32'hccddeeff);
        chk("t1_r0", text0, 32'h00112233);
        chk("t1_last0", last1, 1'b0);
        tick();
        chk("t1_w1", text1, 32'h8899aabb);
        chk("t1_r1", text0, 32'h44556677);
        chk("t1_last1", last1, 1'b0);
        tick();
        chk("t1_w2", text1, 32'h44556677);
        chk("t1_r2", text0, 32'h8899aabb);
        tick();
        chk("t1_w3", text1, 32'h00112233);
        chk("t1_r3", text0, 32'hccddeeff);
        chk("t1_last3", last1, 1'b1);
        chk("t1_last3_r", last0, 1'b1);
        chk("t1_done_early", done1, 1'b0);
        tick();
        chk("t1_done", done1, 1'b1);
        chk("t1_done_r", done0, 1'b1);
        chk("t1_valid_end", valid1, 1'b0);
        chk("t1_busy_end", busy1, 1'b0);
        chk("t1_last_end", last1, 1'b0);
        tick();
        chk("t1_done_off", done1, 1'b0);
        chk("t1_ndone", ndone - snap_d, 1);
        chk("t1_nxfer", nxfer - snap_x, 4);

        // toggling rd_i, reverse order
        snap_d = ndone; snap_x = nxfer;
        rd_i = 1'b0; done_i = 1'b1; text_i = T1;
        tick();
        done_i = 1'b0; text_i = '0;
        chk("t2_w0", text0, 32'h00112233);
        chk("t2_valid", valid0, 1'b1);
        rd_i = 1'b1; tick();
        chk("t2_w1", text0, 32'h44556677);
        rd_i = 1'b0; tick();
        chk("t2_hold1", text0, 32'h44556677);
        rd_i = 1'b1; tick();
        chk("t2_w2", text0, 32'h8899aabb);
        rd_i = 1'b0; tick();
        chk("t2_hold2", text0, 32'h8899aabb);
        chk("t2_last_no", last0, 1'b0);
        rd_i = 1'b1; tick();
        chk("t2_w3", text0, 32'hccddeeff);
        chk("t2_last", last0, 1'b1);
        rd_i = 1'b0; tick();
        chk("t2_hold3", text0, 32'hccddeeff);
        chk("t2_done_hold", done0, 1'b0);
        rd_i = 1'b1; tick();
        chk("t2_done", done0, 1'b1);
        chk("t2_valid_end", valid0, 1'b0);
        rd_i = 1'b0; tick();
        chk("t2_ndone", ndone0 - snap_d, 1);
        chk("t2_nxfer", nxfer - snap_x, 4);

        // back-to-back block on the final transfer
        snap_d = ndone; snap_x = nxfer;
        rd_i = 1'b1; done_i = 1'b1; text_i = T1;
        tick();
        done_i = 1'b0; text_i = '0;
        tick();
        tick();
        tick();
        chk("b2b_w3", text1, 32'h00112233);
        done_i = 1'b1; text_i = T2;
        tick();
        done_i = 1'b0; text_i = '0;
        chk("b2b_done", done1, 1'b1);
        chk("b2b_valid", valid1, 1'b1);
        chk("b2b_n0", text1, 32'hcccccccc);
        chk("b2b_n0_r", text0, 32'hffffffff);
        chk("b2b_last", last1, 1'b0);
        tick();
        chk("b2b_n1", text1, 32'hdddddddd);
        chk("b2b_done_off", done1, 1'b0);
        tick();
        chk("b2b_n2", text1, 32'heeeeeeee);
        tick();
        chk("b2b_n3", text1, 32'hffffffff);
        tick();
        chk("b2b_done2", done1, 1'b1);
        chk("b2b_valid_end", valid1, 1'b0);
        tick();
        chk("b2b_ndone", ndone - snap_d, 2);
        chk("b2b_nxfer", nxfer - snap_x, 8);
        chk("b2b_ovr", ovr1, 1'b0);

        // overrun while cnt=1
        snap_d = ndone; snap_x = nxfer;
        rd_i = 1'b0; done_i = 1'b1; text_i = T1;
        tick();
        done_i = 1'b0; text_i = '0;
        rd_i = 1'b1; tick();
        chk("ov_w1", text1, 32'h8899aabb);
        rd_i = 1'b0; done_i = 1'b1; text_i = T2;
        tick();
        done_i = 1'b0; text_i = '0;
        chk("ov_flag", ovr1, 1'b1);
        chk("ov_text", text1, 32'h8899aabb);
        chk("ov_valid", valid1, 1'b1);
        rd_i = 1'b1; tick();
        chk("ov_w2", text1, 32'h44556677);
        tick();
        chk("ov_w3", text1, 32'h00112233);
        tick();
        chk("ov_done", done1, 1'b1);
        chk("ov_valid_end", valid1, 1'b0);
        tick();
        tick();
        chk("ov_no_extra", valid1, 1'b0);
        chk("ov_sticky", ovr1, 1'b1);
        chk("ov_ndone", ndone - snap_d, 1);
        chk("ov_nxfer", nxfer - snap_x, 4);

        // async reset at cnt=2
        rd_i = 1'b1; done_i = 1'b1; text_i = T1;
        tick();
        done_i = 1'b0; text_i = '0;
        tick();
        tick();
        chk("ar_w2", text1, 32'h44556677);
        rd_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        snap_d = ndone;
        chk("ar_valid", valid1, 1'b0);
        chk("ar_busy", busy1, 1'b0);
        chk("ar_text", text1, 32'h0);
        chk("ar_text_r", text0, 32'h0);
        chk("ar_ovr", ovr1, 1'b0);
        chk("ar_last", last1, 1'b0);
        #1;
        rst = 1'b1;
        tick();

        // rd_i high in IDLE, then a fresh block starts at word 0
        rd_i = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_valid", valid1, 1'b0);
        chk("idle_done", done1, 1'b0);
        chk("ar_ndone", ndone - snap_d, 0);
        done_i = 1'b1; text_i = T2;
        tick();
        done_i = 1'b0; text_i = '0;
        chk("ar_new_w0", text1, 32'hcccccccc);
        chk("ar_new_r0", text0, 32'hffffffff);
        tick();
        tick();
        tick();
        chk("ar_new_w3", text1, 32'hffffffff);
        tick();
        chk("ar_new_done", done1, 1'b1);
        tick();
        chk("ar_new_ndone", ndone - snap_d, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_output_buffer.md
Name: aes_output_buffer

Overview:
- Downstream companion of the AES input buffer: captures the 128-bit result block from the AES core when the core flags completion.
- Serialises the block onto a 32-bit output bus, one word per accepted valid/ready beat.
- Returns a one-cycle completion pulse, which feeds the input buffer's done input so the next block can be loaded.
- Sits between the AES core result and the external 32-bit read interface.

Parameters:
- LSW_FIRST, 1, 1 = word order [31:0], [63:32], [95:64], [127:96]; 0 = reverse order ([127:96] first)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- done_i  input  1  core result strobe; text_i valid in the same cycle
- text_i  input  128  result block from the core
- rd_i  input  1  downstream ready; a beat transfers when valid_o && rd_i at a rising edge
- text_out  output  32  current output word
- valid_o  output  1  text_out holds a valid word
- last_o  output  1  high while the 4th word of a block is presented
- done_o  output  1  one-cycle pulse after the final word transfers
- busy_o  output  1  high while a block is held (state SEND)
- overrun_o  output  1  sticky: done_i arrived while busy and could not be accepted

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, cnt=0, data register=0, text_out=0, valid_o=0, last_o=0, done_o=0, busy_o=0, overrun_o=0. Reset mid-block discards the held data; no done_o is generated.
- All outputs are registered. text_out is a mux of the data register by cnt per LSW_FIRST.
- Counter cnt is 2 bits, range 0..3. It increments on each transfer and wraps to 0 after word 3.
- State IDLE:
  - done_i=1 -> capture text_i, cnt=0, go to SEND.
  - Next cycle: valid_o=1, busy_o=1, word 0 presented (latency 1 cycle from done_i).
- State SEND:
  - valid_o=1 throughout.
  - rd_i=0 -> hold; text_out stable.
  - rd_i=1 with cnt<3 -> cnt+1; next word presented the following cycle.
  - last_o=1 exactly when cnt=3.
- Final transfer (cnt=3, rd_i=1):
  - done_o=1 for one cycle, in the cycle after the transfer edge.
  - With no simultaneous done_i: state=IDLE, valid_o=0, busy_o=0.
- Back-to-back: done_i=1 in the same cycle as the final transfer is accepted.
  - text_i is captured, cnt=0, state stays SEND.
  - valid_o stays 1; word 0 of the new block is presented next cycle.
  - done_o still pulses for the completed block.
- Overrun: done_i=1 in SEND when not the final-transfer cycle.
  - text_i is dropped; the current block is unaffected.
  - overrun_o set and held until reset.
- Throughput: a continuous rd_i=1 gives 4 words in 4 consecutive cycles.

Test Plan:
- Reset, then done_i with text_i=128'h00112233_44556677_8899aabb_ccddeeff, rd_i=1 constant, LSW_FIRST=1 -> valid_o from cycle+1; words ccddeeff, 8899aabb, 44556677, 00112233 on consecutive cycles; last_o only with 00112233; done_o one pulse on the next cycle; valid_o=0 after.
- Same block, LSW_FIRST=0, rd_i toggling 1,0,1,0... -> words 00112233, 44556677, 8899aabb, ccddeeff; text_out held stable during rd_i=0 cycles; exactly 4 transfers; one done_o.
- Back-to-back: second done_i (text_i=128'hffffffff_eeeeeeee_dddddddd_cccccccc) coincident with the final transfer -> valid_o never drops; next word cccccccc; two done_o pulses in total; overrun_o=0.
- Overrun: done_i asserted while cnt=1 -> the remaining words of the first block are unchanged; overrun_o=1 and stays 1; no extra block is emitted.
- Async reset asserted mid-block (cnt=2) without a clock edge -> valid_o, busy_o, text_out, overrun_o go to 0 immediately; no done_o pulse; the next done_i starts from word 0.
- rd_i=1 in IDLE with no done_i -> valid_o=0, no done_o, cnt stays 0.
